klein_serial_core: RTL and testbench

- Byte-serial, handshaked KLEIN encryption core, parametrised over key size: KLEIN-64, KLEIN-80 and KLEIN-96.
- Accepts a key and a 64-bit plaintext as a byte stream, runs one full KLEIN round per clock, then streams the 64-bit ciphertext out one byte per beat.
- Successor to the fixed 96-bit byte-serial datapath. Adds a generic key width, a control FSM, ready/valid flow control and optional key reuse.
- Sits between the byte-wide host/DPA capture interface and the measurement harness.

---
 rtl/klein_pkg.sv | 57 +++++
 rtl/klein_round.sv | 59 +++++
 rtl/klein_serial_core.sv | 168 ++++++++++++++++
 tb/tb_klein_serial_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/klein_pkg.sv
// Shared definitions for the byte-serial KLEIN core: FSM state encoding,
// the 4-bit S-box, GF(2^8) xtime and the round count for each key size.
package klein_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_KEY  = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_ROUND     = 3'd2,
    ST_FINAL     = 3'd3,
    ST_UNLOAD    = 3'd4
  } klein_state_e;

  // KLEIN 4-bit S-box (an involution).
  function automatic logic [3:0] klein_sbox(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'h6;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hD;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  // S-box applied to both nibbles of a byte.
  function automatic logic [7:0] klein_sbox8(input logic [7:0] x);
    return {klein_sbox(x[7:4]), klein_sbox(x[3:0])};
  endfunction

  // Multiply by 2 in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] klein_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Round count for a given key length in bytes.
  function automatic int klein_nr(input int kb);
    case (kb)
      8:       return 12;
      10:      return 16;
      default: return 20;
    endcase
  endfunction

endpackage

// File: rtl/klein_round.sv
// Purely combinational KLEIN round: one full round of the data path plus
// one step of the key schedule, from (state, key, rc) to (nstate, nkey).
module klein_round
  import klein_pkg::*;
#(
  parameter int KEY_BYTES = 12
) (
  input  logic [63:0]            state,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [4:0]             rc,
  output logic [63:0]            nstate,
  output logic [KEY_BYTES*8-1:0] nkey
);

  localparam int KW = KEY_BYTES * 8;
  localparam int HW = KW / 2;

  logic [63:0] mixed_in;
  logic [63:0] sub;
  logic [63:0] rot;
  logic [HW-1:0] half_a, half_b, a_rot, b_rot, na, nb;

  // AES MixColumns on one 4-byte column, byte 0 in the top bits.
  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {klein_xtime(a0) ^ klein_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ klein_xtime(a1) ^ klein_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ klein_xtime(a2) ^ klein_xtime(a3) ^ a3,
            klein_xtime(a0) ^ a0 ^ a1 ^ a2 ^ klein_xtime(a3)};
  endfunction

  // Data path: add round key, S-boxes, rotate by two bytes, mix both columns.
  always_comb begin
    mixed_in = state ^ key[KW-1 -: 64];
    sub = '0;
    for (int i = 0; i < 8; i++) begin
      sub[8*i +: 8] = klein_sbox8(mixed_in[8*i +: 8]);
    end
    rot    = {sub[47:0], sub[63:48]};
    nstate = {mix_col(rot[63:32]), mix_col(rot[31:0])};
  end

  assign half_a = key[KW-1 -: HW];
  assign half_b = key[HW-1:0];
  assign a_rot  = {half_a[HW-9:0], half_a[HW-1 -: 8]};
  assign b_rot  = {half_b[HW-9:0], half_b[HW-1 -: 8]};

  // Key schedule: Feistel-like swap, round constant into a'[2], S-boxes on b'[1], b'[2].
  always_comb begin
    na = b_rot;
    na[HW-17 -: 8] = b_rot[HW-17 -: 8] ^ {3'b000, rc};
    nb = a_rot ^ b_rot;
    nb[HW-9 -: 8]  = klein_sbox8(a_rot[HW-9 -: 8] ^ b_rot[HW-9 -: 8]);
    nb[HW-17 -: 8] = klein_sbox8(a_rot[HW-17 -: 8] ^ b_rot[HW-17 -: 8]);
    nkey = {na, nb};
  end

endmodule

// File: rtl/klein_serial_core.sv
// Byte-serial, handshaked KLEIN-64/80/96 encryption core.
// Loads key then plaintext MSB first, runs one round per clock, then
// streams the ciphertext MSB first. Optional key reuse between blocks is
// enabled by defining KLEIN_KEYREUSE_EN.
//
// Handshake: a byte moves on a rising edge where valid && ready are both
// high; valid may rise at any time and the core never stores an unaccepted
// beat; out_data is held stable while out_valid is high and out_ready low.
module klein_serial_core
  import klein_pkg::*;
#(
  parameter int KEY_BYTES = 12
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_newkey,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output klein_state_e dbg_state
);

  localparam int         KW        = KEY_BYTES * 8;
  localparam int         NR        = klein_nr(KEY_BYTES);
  localparam logic [3:0] KCNT_LAST = 4'(KEY_BYTES - 1);
  localparam logic [4:0] RC_LAST   = 5'(NR);

  if (!(KEY_BYTES == 8 || KEY_BYTES == 10 || KEY_BYTES == 12)) begin : g_bad_key_bytes
    $error("klein_serial_core: KEY_BYTES must be 8, 10 or 12");
  end

  klein_state_e  cur, nxt;
  logic [63:0]   state_q;
  logic [KW-1:0] key_q;
  logic [4:0]    rc_q;
  logic [3:0]    kcnt_q;
  logic [2:0]    dcnt_q;
  logic [63:0]   round_state;
  logic [KW-1:0] round_key;
  logic          in_fire, out_fire, first_newkey;

`ifdef KLEIN_KEYREUSE_EN
  logic [KW-1:0] shadow_q;
  assign first_newkey = in_newkey && (dcnt_q == 3'd0);
`else
  logic unused_newkey;
  assign unused_newkey = in_newkey;
  assign first_newkey  = 1'b0;
`endif

  assign in_ready  = (cur == ST_LOAD_KEY) || (cur == ST_LOAD_DATA);
  assign out_valid = (cur == ST_UNLOAD);
  assign busy      = (cur == ST_ROUND) || (cur == ST_FINAL) || (cur == ST_UNLOAD);
  assign out_data  = out_valid ? state_q[63:56] : 8'h00;
  assign dbg_state = cur;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  klein_round #(.KEY_BYTES(KEY_BYTES)) u_round (
    .state  (state_q),
    .key    (key_q),
    .rc     (rc_q),
    .nstate (round_state),
    .nkey   (round_key)
  );

  // FSM state register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) cur <= ST_LOAD_KEY;
    else        cur <= nxt;
  end

  // FSM next-state logic.
  always_comb begin
    nxt = cur;
    case (cur)
      ST_LOAD_KEY: begin
        if (in_fire && kcnt_q == KCNT_LAST) nxt = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (in_fire) begin
          if (first_newkey)         nxt = ST_LOAD_KEY;
          else if (dcnt_q == 3'd7)  nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (rc_q == RC_LAST) nxt = ST_FINAL;
      end
      ST_FINAL: nxt = ST_UNLOAD;
      ST_UNLOAD: begin
`ifdef KLEIN_KEYREUSE_EN
        if (out_fire && dcnt_q == 3'd7) nxt = ST_LOAD_DATA;
`else
        if (out_fire && dcnt_q == 3'd7) nxt = ST_LOAD_KEY;
`endif
      end
      default: nxt = ST_LOAD_KEY;
    endcase
  end

  // Data path: shift-in, round iteration, final whitening and shift-out.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= 5'd1;
      kcnt_q  <= 4'd0;
      dcnt_q  <= 3'd0;
    end else begin
      case (cur)
        ST_LOAD_KEY: begin
          if (in_fire) begin
            key_q  <= {key_q[KW-9:0], in_data};
            kcnt_q <= (kcnt_q == KCNT_LAST) ? 4'd0 : kcnt_q + 4'd1;
          end
        end
        ST_LOAD_DATA: begin
          if (in_fire) begin
            if (first_newkey) begin
              // This byte opens a new key rather than a plaintext block.
              key_q  <= {key_q[KW-9:0], in_data};
              kcnt_q <= 4'd1;
            end else begin
              state_q <= {state_q[55:0], in_data};
              dcnt_q  <= dcnt_q + 3'd1;
            end
          end
        end
        ST_ROUND: begin
          state_q <= round_state;
          key_q   <= round_key;
          rc_q    <= rc_q + 5'd1;
        end
        ST_FINAL: begin
          state_q <= state_q ^ key_q[KW-1 -: 64];
          rc_q    <= 5'd1;
        end
        ST_UNLOAD: begin
          if (out_fire) begin
            state_q <= {state_q[55:0], 8'h00};
            dcnt_q  <= dcnt_q + 3'd1;
`ifdef KLEIN_KEYREUSE_EN
            // Rounds consumed the working key; restore the master key.
            if (dcnt_q == 3'd7) key_q <= shadow_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KLEIN_KEYREUSE_EN
  // Master-key shadow: captures every key byte as it is loaded.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (in_fire && (cur == ST_LOAD_KEY || (cur == ST_LOAD_DATA && first_newkey))) begin
      shadow_q <= {shadow_q[KW-9:0], in_data};
    end
  end
`endif

endmodule

// File: tb/tb_klein_serial_core.sv
// Self-checking bench for klein_serial_core (KEY_BYTES=12) with a
// byte-array reference model of KLEIN.
module tb_klein_serial_core;
  import klein_pkg::*;

  localparam int KB  = 12;
  localparam int NRT = (KB == 8) ? 12 : (KB == 10) ? 16 : 20;

  // ---------------- clock / reset / DUT ----------------
  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_newkey = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  klein_state_e dbg_state;

  always #5 ck = ~ck;

  klein_serial_core #(.KEY_BYTES(KB)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_newkey (in_newkey),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout waiting for handshake", tag);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] sbox_t [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                              4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

  function automatic logic [7:0] m_sub(input logic [7:0] v);
    return {sbox_t[v[7:4]], sbox_t[v[3:0]]};
  endfunction

  // Generic GF(2^8) product, polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [63:0] model_enc(input logic [KB*8-1:0] key, input logic [63:0] pt);
    logic [7:0] st [8];
    logic [7:0] t  [8];
    logic [7:0] k  [KB];
    logic [7:0] na [KB/2];
    logic [7:0] nb [KB/2];
    logic [7:0] a0, a1, a2, a3;
    logic [63:0] res;
    int h;
    h = KB / 2;
    for (int i = 0; i < 8; i++)  st[i] = pt[63-8*i -: 8];
    for (int i = 0; i < KB; i++) k[i]  = key[KB*8-1-8*i -: 8];
    for (int r = 1; r <= NRT; r++) begin
      for (int i = 0; i < 8; i++) t[i] = m_sub(st[i] ^ k[i]);
      for (int i = 0; i < 8; i++) st[i] = t[(i + 2) % 8];
      for (int c = 0; c < 8; c += 4) begin
        a0 = st[c]; a1 = st[c+1]; a2 = st[c+2]; a3 = st[c+3];
        st[c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
        st[c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
        st[c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
        st[c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
      for (int j = 0; j < KB/2; j++) begin
        na[j] = k[h + (j + 1) % h];
        nb[j] = k[(j + 1) % h] ^ k[h + (j + 1) % h];
      end
      na[2] = na[2] ^ 8'(r);
      nb[1] = m_sub(nb[1]);
      nb[2] = m_sub(nb[2]);
      for (int j = 0; j < KB/2; j++) begin
        k[j]     = na[j];
        k[h + j] = nb[j];
      end
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[63-8*i -: 8] = st[i] ^ k[i];
    return res;
  endfunction

  function automatic logic [KB*8-1:0] rand_key();
    logic [KB*8-1:0] v;
    for (int i = 0; i < KB; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [63:0] rand_pt();
    return {$urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic nk, input int maxgap);
    int n;
    in_valid = 1'b0;
    idle(int'($urandom_range(0, maxgap)));
    in_data   = b;
    in_newkey = nk;
    in_valid  = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge ck);
      #1;
      n++;
    end
    if (n >= 100) timeout_fail("send_ready");
    @(posedge ck);
    #1;
    in_valid  = 1'b0;
    in_newkey = 1'b0;
  endtask

  // First key byte carries in_newkey=1 so the block loads in either build.
  task automatic send_block(input logic [KB*8-1:0] key, input logic [63:0] pt,
                            input bit with_key, input int maxgap);
    if (with_key) begin
      for (int i = 0; i < KB; i++) send_byte(key[KB*8-1-8*i -: 8], (i == 0), maxgap);
    end
    for (int i = 0; i < 8; i++) send_byte(pt[63-8*i -: 8], 1'b0, maxgap);
  endtask

  task automatic recv_block(output logic [63:0] ct, output int lat,
                            input bit stall, input bit junk, input int beats);
    int n;
    logic [7:0] held;
    ct  = '0;
    lat = -1;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    for (int b = 0; b < beats; b++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
        @(posedge ck);
        #1;
        n++;
        if (junk) in_data = 8'($urandom);
      end
      if (n >= 200) begin
        timeout_fail("recv_valid");
        in_valid = 1'b0;
        return;
      end
      if (b == 0) lat = n;
      check("no_in_ready_during_output", {63'd0, in_ready}, 64'd0);
      if (stall) begin
        held = out_data;
        repeat ($urandom_range(0, 3)) begin
          out_ready = 1'b0;
          @(posedge ck);
          #1;
          check("out_data_hold", {56'd0, out_data}, {56'd0, held});
        end
      end
      ct = {ct[55:0], out_data};
      out_ready = 1'b1;
      @(posedge ck);
      #1;
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_out_data"},  {56'd0, out_data},  64'd0);
    check({tag, "_state"},     {61'd0, dbg_state}, {61'd0, ST_LOAD_KEY});
  endtask

  // Encrypt one random block and compare with the model.
  task automatic random_block(input string tag, input int maxgap, input bit stall, input bit junk);
    logic [KB*8-1:0] k;
    logic [63:0] p, ct;
    int lat;
    k = rand_key();
    p = rand_pt();
    send_block(k, p, 1'b1, maxgap);
    recv_block(ct, lat, stall, junk, 8);
    check(tag, ct, model_enc(k, p));
    check({tag, "_latency"}, 64'(lat), 64'(NRT + 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [KB*8-1:0] k1, k2;
    logic [63:0] p1, ct;
    int lat;

    #12;
    check_reset_outputs("reset");
    @(posedge ck);
    #1;
    rst_n = 1'b1;

    // Known-answer vector: zero key, all-ones plaintext.
    send_block('0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    recv_block(ct, lat, 1'b0, 1'b0, 8);
    check("kat_zero_key", ct, 64'hDB9F_A7D3_3D8E_8E36);
    check("kat_latency", 64'(lat), 64'(NRT + 1));

    // in_valid held high with junk through ROUND/FINAL/UNLOAD.
    random_block("junk_valid_block", 0, 1'b1, 1'b1);
    random_block("after_junk_block", 1, 1'b0, 1'b0);

    // Random gaps and output stalls.
    for (int i = 0; i < 100; i++) random_block("random_block", 2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of ROUND (rc=5).
    k1 = rand_key();
    p1 = rand_pt();
    send_block(k1, p1, 1'b1, 0);
    idle(4);
    check("pre_reset_round", {61'd0, dbg_state}, {61'd0, ST_ROUND});
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_round");
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    random_block("after_round_reset", 1, 1'b1, 1'b0);

    // Asynchronous reset after three output bytes.
    send_block(rand_key(), rand_pt(), 1'b1, 0);
    recv_block(ct, lat, 1'b0, 1'b0, 3);
    check("pre_reset_unload", {61'd0, dbg_state}, {61'd0, ST_UNLOAD});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_unload");
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    random_block("after_unload_reset", 1, 1'b1, 1'b0);

`ifdef KLEIN_KEYREUSE_EN
    // Key reuse: K, two blocks, then a fresh key K2.
    k1 = rand_key();
    k2 = rand_key();
    p1 = rand_pt();
    send_block(k1, p1, 1'b1, 1);
    recv_block(ct, lat, 1'b1, 1'b0, 8);
    check("reuse_first", ct, model_enc(k1, p1));
    p1 = rand_pt();
    send_block(k1, p1, 1'b0, 0);
    check("reuse_eight_beats", {61'd0, dbg_state}, {61'd0, ST_ROUND});
    recv_block(ct, lat, 1'b1, 1'b0, 8);
    check("reuse_second", ct, model_enc(k1, p1));
    p1 = rand_pt();
    send_block(k2, p1, 1'b1, 1);
    recv_block(ct, lat, 1'b1, 1'b0, 8);
    check("reuse_new_key", ct, model_enc(k2, p1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
